// File: rtl/pg_input_filter.sv
// rtl/pg_input_filter.sv - synchronizing, deglitching power-good filter with optional fault capture (PG_FAULT_CAPTURE_EN)
`timescale 1ns/1ps
module pg_input_filter #(
  parameter int RAILS    = 15,
  parameter int FILT_LEN = 8
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic [RAILS-1:0] PG_RAW,
  input  logic             ARM,
  input  logic             CLR_FAULT,
  output logic [RAILS-1:0] PG_FILT,
  output logic [RAILS-1:0] PG_RISE,
  output logic [RAILS-1:0] PG_FALL,
  output logic             FAULT,
  output logic [RAILS-1:0] FAULT_VEC,
  output logic [3:0]       FAULT_IDX
);

  localparam logic [3:0] CntMax = 4'(FILT_LEN - 1);

  logic [RAILS-1:0] s1_q, s2_q;
  logic [RAILS-1:0] f_q, f_d;
  logic [RAILS-1:0] rise_q, rise_d;
  logic [RAILS-1:0] fall_q, fall_d;
  logic [3:0]       cnt_q [RAILS];
  logic [3:0]       cnt_d [RAILS];

  // Two-flop synchronizer on the asynchronous rail pins
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= PG_RAW;
      s2_q <= s1_q;
    end
  end

  // Per-rail stability counter: accept the new level on the FILT_LEN-th differing sample
  always_comb begin
    f_d    = f_q;
    rise_d = '0;
    fall_d = '0;
    for (int r = 0; r < RAILS; r++) begin
      cnt_d[r] = 4'd0;
      if (s2_q[r] != f_q[r]) begin
        if (cnt_q[r] == CntMax) begin
          f_d[r]    = s2_q[r];
          rise_d[r] = s2_q[r];
          fall_d[r] = ~s2_q[r];
        end else begin
          cnt_d[r] = cnt_q[r] + 4'd1;
        end
      end
    end
  end

  // Filter state and edge pulses; pulses land in the same cycle as the filtered change
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      f_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int r = 0; r < RAILS; r++) cnt_q[r] <= 4'd0;
    end else begin
      f_q    <= f_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int r = 0; r < RAILS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign PG_FILT = f_q;
  assign PG_RISE = rise_q;
  assign PG_FALL = fall_q;

`ifdef PG_FAULT_CAPTURE_EN
  logic             fault_q, fault_d;
  logic [RAILS-1:0] fvec_q, fvec_d;
  logic [3:0]       fidx_q, fidx_d;
  logic [3:0]       low_idx;

  // Lowest-index rail among the ones that just fell
  always_comb begin
    low_idx = 4'd0;
    for (int r = RAILS - 1; r >= 0; r--) begin
      if (fall_q[r]) low_idx = 4'(r);
    end
  end

  // Sticky capture; a fall coinciding with a clear wins so no event is lost
  always_comb begin
    fault_d = fault_q;
    fvec_d  = fvec_q;
    fidx_d  = fidx_q;
    if (ARM && (fall_q != '0) && (!fault_q || CLR_FAULT)) begin
      fault_d = 1'b1;
      fvec_d  = f_q;
      fidx_d  = low_idx;
    end else if (CLR_FAULT) begin
      fault_d = 1'b0;
      fvec_d  = '0;
      fidx_d  = 4'd0;
    end
  end

  // Fault capture registers
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      fault_q <= 1'b0;
      fvec_q  <= '0;
      fidx_q  <= 4'd0;
    end else begin
      fault_q <= fault_d;
      fvec_q  <= fvec_d;
      fidx_q  <= fidx_d;
    end
  end

  assign FAULT     = fault_q;
  assign FAULT_VEC = fvec_q;
  assign FAULT_IDX = fidx_q;
`else
  logic unused_fault_inputs;
  assign unused_fault_inputs = ^{ARM, CLR_FAULT};

  assign FAULT     = 1'b0;
  assign FAULT_VEC = '0;
  assign FAULT_IDX = 4'd0;
`endif

endmodule

// File: tb/tb_pg_input_filter.sv
// tb/tb_pg_input_filter.sv - directed-vector bench for pg_input_filter
`timescale 1ns/1ps
module tb_pg_input_filter;

  localparam int RAILS    = 15;
  localparam int FILT_LEN = 8;

  logic             CLK_IN = 1'b0;
  logic             RST;
  logic [RAILS-1:0] PG_RAW;
  logic             ARM;
  logic             CLR_FAULT;
  logic [RAILS-1:0] PG_FILT, PG_RISE, PG_FALL, FAULT_VEC;
  logic             FAULT;
  logic [3:0]       FAULT_IDX;

  int vectors = 0;
  int miscompares = 0;
  logic [RAILS-1:0] rise_acc, fall_acc;
  logic fault_en;

  pg_input_filter #(.RAILS(RAILS), .FILT_LEN(FILT_LEN)) dut (
    .CLK_IN   (CLK_IN),
    .RST      (RST),
    .PG_RAW   (PG_RAW),
    .ARM      (ARM),
    .CLR_FAULT(CLR_FAULT),
    .PG_FILT  (PG_FILT),
    .PG_RISE  (PG_RISE),
    .PG_FALL  (PG_FALL),
    .FAULT    (FAULT),
    .FAULT_VEC(FAULT_VEC),
    .FAULT_IDX(FAULT_IDX)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge CLK_IN);
      #1;
      rise_acc |= PG_RISE;
      fall_acc |= PG_FALL;
    end
  endtask

  task automatic clr_acc();
    rise_acc = '0;
    fall_acc = '0;
  endtask

  task automatic check_fault(input string tag, input logic f, input logic [31:0] vec, input logic [3:0] idx);
    check_vec({tag, "_fault"}, 32'(FAULT), fault_en ? 32'(f) : 32'd0);
    check_vec({tag, "_vec"}, 32'(FAULT_VEC), fault_en ? vec : 32'd0);
    check_vec({tag, "_idx"}, 32'(FAULT_IDX), fault_en ? 32'(idx) : 32'd0);
  endtask

  initial begin
`ifdef PG_FAULT_CAPTURE_EN
    fault_en = 1'b1;
`else
    fault_en = 1'b0;
`endif
    RST = 1'b1; PG_RAW = '0; ARM = 1'b0; CLR_FAULT = 1'b0;
    clr_acc();
    #1;
    check_vec("rst_filt", 32'(PG_FILT), 32'h0);
    check_vec("rst_rise", 32'(PG_RISE), 32'h0);
    check_vec("rst_fall", 32'(PG_FALL), 32'h0);
    check_fault("rst", 1'b0, 32'h0, 4'd0);
    run(3);
    RST = 1'b0;
    run(3);

    // single rail rise: 9 edges after the sampling edge nothing, 10th shows it
    PG_RAW = 15'h0010;
    run(9);
    check_vec("rise4_early", 32'(PG_FILT), 32'h0);
    run(1);
    check_vec("rise4_filt", 32'(PG_FILT), 32'h0010);
    check_vec("rise4_pulse", 32'(PG_RISE), 32'h0010);
    run(1);
    check_vec("rise4_pulse_end", 32'(PG_RISE), 32'h0);

    // remaining rails rise together
    PG_RAW = 15'h7FFF;
    run(10);
    check_vec("all_filt", 32'(PG_FILT), 32'h7FFF);
    check_vec("all_rise", 32'(PG_RISE), 32'h7FEF);
    run(1);

    // 5-cycle glitch on rail 2 is rejected
    clr_acc();
    PG_RAW = 15'h7FFB; run(5);
    PG_RAW = 15'h7FFF; run(12);
    check_vec("glitch5_filt", 32'(PG_FILT), 32'h7FFF);
    check_vec("glitch5_fall", 32'(fall_acc), 32'h0);
    check_fault("glitch5", 1'b0, 32'h0, 4'd0);

    // two FILT_LEN-1 glitches split by one good sample: count restarts
    clr_acc();
    PG_RAW = 15'h7FFB; run(7);
    PG_RAW = 15'h7FFF; run(1);
    PG_RAW = 15'h7FFB; run(7);
    PG_RAW = 15'h7FFF; run(12);
    check_vec("glitch7_filt", 32'(PG_FILT), 32'h7FFF);
    check_vec("glitch7_fall", 32'(fall_acc), 32'h0);

    // FILT_LEN-long drop is accepted; disarmed so no fault
    PG_RAW = 15'h7FFB; run(8);
    PG_RAW = 15'h7FFF; run(1);
    check_vec("drop8_early", 32'(PG_FILT), 32'h7FFF);
    run(1);
    check_vec("drop8_filt", 32'(PG_FILT), 32'h7FFB);
    check_vec("drop8_fall", 32'(PG_FALL), 32'h0004);
    run(8);
    check_vec("drop8_back", 32'(PG_FILT), 32'h7FFF);
    check_vec("drop8_rise", 32'(PG_RISE), 32'h0004);
    run(1);
    check_fault("disarmed", 1'b0, 32'h0, 4'd0);

    // armed: rails 9 and 3 drop together
    ARM = 1'b1;
    PG_RAW = 15'h7DF7; run(10);
    check_vec("dual_fall", 32'(PG_FALL), 32'h0208);
    check_vec("dual_filt", 32'(PG_FILT), 32'h7DF7);
    run(1);
    check_fault("dual", 1'b1, 32'h7DF7, 4'd3);

    // later drop on rail 0 leaves snapshot untouched, then clear
    PG_RAW = 15'h7DF6; run(10);
    check_vec("r0_fall", 32'(PG_FALL), 32'h0001);
    run(1);
    check_fault("sticky", 1'b1, 32'h7DF7, 4'd3);
    CLR_FAULT = 1'b1; run(1); CLR_FAULT = 1'b0;
    check_fault("cleared", 1'b0, 32'h0, 4'd0);

    // fault on rail 5, then clear coinciding with a fall on rail 7
    PG_RAW = 15'h7DD6; run(11);
    check_fault("r5", 1'b1, 32'h7DD6, 4'd5);
    PG_RAW = 15'h7D56; run(10);
    check_vec("r7_fall", 32'(PG_FALL), 32'h0080);
    CLR_FAULT = 1'b1; run(1); CLR_FAULT = 1'b0;
    check_fault("clr_race", 1'b1, 32'h7D56, 4'd7);

    // disarming keeps the fault
    ARM = 1'b0; run(2);
    check_fault("disarm_hold", 1'b1, 32'h7D56, 4'd7);
    CLR_FAULT = 1'b1; run(1); CLR_FAULT = 1'b0;
    check_fault("clr2", 1'b0, 32'h0, 4'd0);

    // reset everything, then abort a rail-1 rise at CNT=5
    RST = 1'b1; PG_RAW = '0; run(1); RST = 1'b0; run(3);
    PG_RAW = 15'h0002; run(7);
    #2 RST = 1'b1;
    #1;
    check_vec("mid_rst_filt", 32'(PG_FILT), 32'h0);
    check_vec("mid_rst_rise", 32'(PG_RISE), 32'h0);
    check_vec("mid_rst_fall", 32'(PG_FALL), 32'h0);
    run(1);
    RST = 1'b0;
    clr_acc();
    run(9);
    check_vec("rerise_early", 32'(PG_FILT), 32'h0);
    check_vec("rerise_nopulse", 32'(rise_acc), 32'h0);
    run(1);
    check_vec("rerise_filt", 32'(PG_FILT), 32'h0002);
    check_vec("rerise_pulse", 32'(PG_RISE), 32'h0002);
    check_vec("rerise_nofall", 32'(fall_acc), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
